// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: mode encodings, flag bit positions and FSM states.
package alu_pkg;
   localparam int MODE_BITS = 4;

   localparam logic [3:0] MODE_ADD = 4'd0;
   localparam logic [3:0] MODE_SUB = 4'd1;
   localparam logic [3:0] MODE_AND = 4'd2;
   localparam logic [3:0] MODE_OR  = 4'd3;
   localparam logic [3:0] MODE_XOR = 4'd4;
   localparam logic [3:0] MODE_NOT = 4'd5;
   localparam logic [3:0] MODE_SHL = 4'd6;
   localparam logic [3:0] MODE_SHR = 4'd7;
   localparam logic [3:0] MODE_ROL = 4'd8;
   localparam logic [3:0] MODE_ROR = 4'd9;
   localparam logic [3:0] MODE_INC = 4'd10;
   localparam logic [3:0] MODE_DEC = 4'd11;
   localparam logic [3:0] MODE_ADC = 4'd12;
   localparam logic [3:0] MODE_SBB = 4'd13;
   localparam logic [3:0] MODE_MUL = 4'd14;
   localparam logic [3:0] MODE_CMP = 4'd15;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_S = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_e;

   function automatic logic [3:0] pack_flags(input logic z, input logic c, input logic s, input logic o);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_S] = s;
      f[FLAG_O] = o;
      return f;
   endfunction
endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles after start.
// done_o is combinational in the last iteration cycle; product_o then carries the final product.
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]   cnt_q;

   assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   // Exposing acc_d lets the caller register the result on the final iteration edge.
   assign product_o = acc_d;
   assign done_o    = (cnt_q == CNT_W'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (start_i) begin
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= CNT_W'(WIDTH);
      end else if (cnt_q != '0) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CNT_W'(1);
      end
   end
endmodule

// File: rtl/alu_seq.sv
// Registered 16-mode ALU: single-cycle ops land on the accept edge, MUL takes WIDTH cycles.
// in_ready is low only while a multiply is in flight; inputs are ignored during that time.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int MODE_W = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  Operand1,
   input  logic [WIDTH-1:0]  Operand2,
   input  logic [MODE_W-1:0] Mode,
   input  logic              flags_clear,
   output logic [WIDTH-1:0]  Out,
   output logic              out_valid,
   output logic [3:0]        Flags
);
   localparam int MSB = WIDTH - 1;
   localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [3:0]         flags_q, flags_d;
   logic               out_valid_q, out_valid_d;

   logic               accept;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH-1:0]   mul_lo;
   logic               mul_hi_nz;
   logic [3:0]         mul_flags;

   logic [WIDTH:0]     ext_a, ext_b, wide;
   logic               cin;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_o;
   logic [3:0]         alu_flags;

   assign in_ready  = (state_q == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (Mode == MODE_MUL);

   assign ext_a = {1'b0, Operand1};
   assign ext_b = {1'b0, Operand2};
   assign cin   = flags_q[FLAG_C];

   // Carry/borrow falls out of bit WIDTH of the extended sum or difference.
   always_comb begin
      wide    = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_o   = 1'b0;
      case (Mode)
         MODE_ADD, MODE_ADC: begin
            wide    = ext_a + ext_b + {{WIDTH{1'b0}}, (Mode == MODE_ADC) & cin};
            alu_res = wide[MSB:0];
            alu_c   = wide[WIDTH];
            alu_o   = (Operand1[MSB] == Operand2[MSB]) && (alu_res[MSB] != Operand1[MSB]);
         end
         MODE_SUB, MODE_SBB, MODE_CMP: begin
            wide    = ext_a - ext_b - {{WIDTH{1'b0}}, (Mode == MODE_SBB) & cin};
            alu_res = wide[MSB:0];
            alu_c   = wide[WIDTH];
            alu_o   = (Operand1[MSB] != Operand2[MSB]) && (alu_res[MSB] != Operand1[MSB]);
         end
         MODE_INC: begin
            wide    = ext_a + ONE_X;
            alu_res = wide[MSB:0];
            alu_c   = wide[WIDTH];
            alu_o   = !Operand1[MSB] && alu_res[MSB];
         end
         MODE_DEC: begin
            wide    = ext_a - ONE_X;
            alu_res = wide[MSB:0];
            alu_c   = wide[WIDTH];
            alu_o   = Operand1[MSB] && !alu_res[MSB];
         end
         MODE_AND: alu_res = Operand1 & Operand2;
         MODE_OR:  alu_res = Operand1 | Operand2;
         MODE_XOR: alu_res = Operand1 ^ Operand2;
         MODE_NOT: alu_res = ~Operand1;
         MODE_SHL: begin
            alu_res = {Operand1[MSB-1:0], 1'b0};
            alu_c   = Operand1[MSB];
         end
         MODE_SHR: begin
            alu_res = {1'b0, Operand1[MSB:1]};
            alu_c   = Operand1[0];
         end
         MODE_ROL: begin
            alu_res = {Operand1[MSB-1:0], Operand1[MSB]};
            alu_c   = Operand1[MSB];
         end
         MODE_ROR: begin
            alu_res = {Operand1[0], Operand1[MSB:1]};
            alu_c   = Operand1[0];
         end
         default: ;
      endcase
   end

   assign alu_flags = pack_flags(alu_res == '0, alu_c, alu_res[MSB], alu_o);
   assign mul_lo    = mul_product[MSB:0];
   assign mul_hi_nz = |mul_product[2*WIDTH-1:WIDTH];
   assign mul_flags = pack_flags(mul_lo == '0, mul_hi_nz, mul_lo[MSB], mul_hi_nz);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clock     (clock),
      .reset_n   (reset_n),
      .start_i   (mul_start),
      .a_i       (Operand1),
      .b_i       (Operand2),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   // A result write takes priority over flags_clear on the same edge.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      flags_d     = flags_clear ? 4'b0000 : flags_q;
      out_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (Mode == MODE_MUL) begin
                  state_d = ST_MUL_BUSY;
               end else begin
                  if (Mode != MODE_CMP) out_d = alu_res;
                  flags_d     = alu_flags;
                  out_valid_d = 1'b1;
               end
            end
         end
         ST_MUL_BUSY: begin
            if (mul_done) begin
               out_d       = mul_lo;
               flags_d     = mul_flags;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         out_q       <= '0;
         flags_q     <= 4'b0000;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign Out       = out_q;
   assign Flags     = flags_q;
   assign out_valid = out_valid_q;
endmodule
